// File: rtl/npn_eval_pipe.sv
// Two-stage NPN-transformed truth-table evaluator with drain-then-commit
// reconfiguration and a saturating result counter.
module npn_eval_pipe #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 16,
  localparam int TT_W = 2**N_IN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cfg_we,
  input  logic [TT_W-1:0]   i_cfg_tt,
  input  logic [3*N_IN-1:0] i_cfg_perm,
  input  logic [N_IN-1:0]   i_cfg_neg_in,
  input  logic              i_cfg_neg_out,
  output logic              o_cfg_ack,
  output logic              o_cfg_err,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [N_IN-1:0]   i_in_x,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_y,
  output logic [CNT_W-1:0]  o_eval_cnt,
  output logic              o_busy
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_COMMIT} state_t;

  state_t              r_state;
  logic [TT_W-1:0]     r_tt;
  logic [3*N_IN-1:0]   r_perm;
  logic [N_IN-1:0]     r_neg_in;
  logic                r_neg_out;
  logic                r_cfg_ack;
  logic                r_cfg_err;
  logic                r_s1_valid;
  logic [N_IN-1:0]     r_s1_p;
  logic                r_s2_valid;
  logic                r_s2_y;
  logic [CNT_W-1:0]    r_eval_cnt;

  logic                w_busy;
  logic                w_s1_adv;
  logic                w_out_xfer;
  logic                w_in_ready;
  logic                w_in_xfer;
  logic                w_cfg_ok;
  logic                w_commit_ok;
  logic [7:0]          w_x_ext;
  logic [N_IN-1:0]     w_p;

  assign w_busy      = r_s1_valid | r_s2_valid;
  assign w_out_xfer  = r_s2_valid & i_out_ready;
  assign w_s1_adv    = r_s1_valid & (~r_s2_valid | i_out_ready);
  assign w_in_ready  = ~i_cfg_we & (~r_s1_valid | w_s1_adv);
  assign w_in_xfer   = i_in_valid & w_in_ready;
  assign w_commit_ok = (r_state == ST_COMMIT) & w_cfg_ok;

  // Zero-extended so a 3-bit perm field always indexes inside the vector.
  always_comb begin
    w_x_ext = 8'(i_in_x);
    w_p     = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_p[i] = w_x_ext[r_perm[3*i +: 3]] ^ r_neg_in[i];
    end
  end

  always_comb begin
    w_cfg_ok = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (i_cfg_perm[3*i +: 3] >= 3'(N_IN)) w_cfg_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_p     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_y     <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
        r_s1_p     <= w_p;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_y     <= r_tt[r_s1_p] ^ r_neg_out;
      end else if (w_out_xfer) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  // The requester keeps cfg_we high during the ack/err cycle, so RUN ignores it then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_cfg_ack <= 1'b0;
      r_cfg_err <= 1'b0;
      r_tt      <= '0;
      r_neg_in  <= '0;
      r_neg_out <= 1'b0;
      for (int i = 0; i < N_IN; i++) r_perm[3*i +: 3] <= 3'(i);
    end else begin
      r_cfg_ack <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (i_cfg_we && !r_cfg_ack && !r_cfg_err)
            r_state <= w_busy ? ST_DRAIN : ST_COMMIT;
        end
        ST_DRAIN: begin
          if (!w_busy) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          if (w_cfg_ok) begin
            r_tt      <= i_cfg_tt;
            r_perm    <= i_cfg_perm;
            r_neg_in  <= i_cfg_neg_in;
            r_neg_out <= i_cfg_neg_out;
            r_cfg_ack <= 1'b1;
          end else begin
            r_cfg_err <= 1'b1;
          end
          r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_cnt <= '0;
    end else if (w_commit_ok) begin
      r_eval_cnt <= '0;
    end else if (w_out_xfer && (r_eval_cnt != {CNT_W{1'b1}})) begin
      r_eval_cnt <= r_eval_cnt + 1'b1;
    end
  end

  assign o_cfg_ack   = r_cfg_ack;
  assign o_cfg_err   = r_cfg_err;
  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_s2_valid;
  assign o_out_y     = r_s2_y;
  assign o_eval_cnt  = r_eval_cnt;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_npn_eval_pipe.sv
// Scoreboard bench for npn_eval_pipe: stimulus pushes expected results from a
// truth-table model; a monitor pops and compares on each output transfer.
module tb_npn_eval_pipe;
  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_tt = '0;
  logic [11:0] cfg_perm = '0;
  logic [3:0]  cfg_neg_in = '0;
  logic        cfg_neg_out = 1'b0;
  logic        cfg_ack, cfg_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_y;
  logic [CW-1:0] eval_cnt;
  logic        busy;

  npn_eval_pipe #(.N_IN(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_we(cfg_we), .i_cfg_tt(cfg_tt), .i_cfg_perm(cfg_perm),
    .i_cfg_neg_in(cfg_neg_in), .i_cfg_neg_out(cfg_neg_out),
    .o_cfg_ack(cfg_ack), .o_cfg_err(cfg_err),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_x(in_x),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_y(out_y),
    .o_eval_cnt(eval_cnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_q[$];
  bit rand_rdy = 1'b0;

  bit [15:0] m_tt;
  int        m_perm[4];
  bit [3:0]  m_nin;
  bit        m_nout;
  int        m_cnt;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tt = '0;
    for (int i = 0; i < 4; i++) m_perm[i] = i;
    m_nin  = '0;
    m_nout = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic bit ref_y(bit [3:0] x);
    int idx = 0;
    for (int i = 0; i < 4; i++)
      if (x[m_perm[i]] ^ m_nin[i]) idx += (1 << i);
    return m_tt[idx] ^ m_nout;
  endfunction

  // Monitor: output is stable from just after the falling edge to the next rising edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got out_y=%0d expected no output at %0t", out_y, $time);
      end else begin
        bit e;
        e = sb_q.pop_front();
        check("out_y", out_y, e);
      end
      if (m_cnt < CMAX) m_cnt++;
    end
  end

  always @(negedge clk) if (rand_rdy) out_ready = ($urandom % 4) != 0;

  task automatic send(bit [3:0] x);
    bit rdy;
    int t = 0;
    in_valid = 1'b1;
    in_x = x;
    forever begin
      #1;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        sb_q.push_back(ref_y(x));
        break;
      end
      t++;
      if (t > 300) begin
        check("send_timeout", t, 0);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_cfg(bit [15:0] tt, bit [11:0] perm, bit [3:0] nin, bit nout, int hold);
    bit ok = 1'b1;
    bit got = 1'b0;
    int t = 0;
    for (int i = 0; i < 4; i++) if (perm[3*i +: 3] >= 3'd4) ok = 1'b0;
    cfg_we = 1'b1;
    cfg_tt = tt;
    cfg_perm = perm;
    cfg_neg_in = nin;
    cfg_neg_out = nout;
    while (!got && t < 400) begin
      @(negedge clk);
      t++;
      if (t <= hold) begin
        check("drain_in_ready", in_ready, 0);
        check("drain_busy", busy, 1);
      end
      if (t == hold) out_ready = 1'b1;
      if (cfg_ack || cfg_err) got = 1'b1;
    end
    if (!got) begin
      check("cfg_timeout", t, 0);
    end else begin
      check("cfg_ack", cfg_ack, ok);
      check("cfg_err", cfg_err, !ok);
      if (ok) begin
        m_tt = tt;
        for (int i = 0; i < 4; i++) m_perm[i] = perm[3*i +: 3];
        m_nin = nin;
        m_nout = nout;
        m_cnt = 0;
      end
      check("cfg_eval_cnt", eval_cnt, m_cnt);
    end
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_single_pulse", cfg_ack | cfg_err, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb_q.size() != 0 || busy) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) check("idle_timeout", t, 0);
    @(negedge clk);
    check("eval_cnt", eval_cnt, m_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit [11:0] rp;
    model_reset();
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_cfg_ack", cfg_ack, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_eval_cnt", eval_cnt, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1);
    @(negedge clk);

    // Reset config: tt=0 so every result is 0; check two-stage latency.
    send(4'hF);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    wait_idle();

    do_cfg(16'h8000, 12'b011_010_001_000, 4'h0, 1'b0, 0);
    send(4'hF);
    send(4'hE);
    wait_idle();

    do_cfg(16'h8000, 12'b011_010_001_000, 4'hF, 1'b1, 0);
    send(4'h0);
    send(4'h5);
    wait_idle();

    do_cfg(16'h0002, 12'b000_001_010_011, 4'h0, 1'b0, 0);
    send(4'h8);
    send(4'h1);
    wait_idle();

    // Backpressure: two accepts fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(4'h8);
    send(4'h1);
    in_valid = 1'b1;
    in_x = 4'h9;
    #1;
    check("stall_in_ready", in_ready, 0);
    check("stall_busy", busy, 1);
    @(negedge clk);
    out_ready = 1'b1;
    send(4'h9);
    wait_idle();

    // Rejected config while two items are in flight.
    out_ready = 1'b0;
    send(4'h8);
    send(4'h1);
    do_cfg(16'hFFFF, 12'b000_101_010_011, 4'h3, 1'b1, 4);
    send(4'h8);
    send(4'h1);
    wait_idle();

    // Saturation of the counter.
    for (int i = 0; i < CMAX + 4; i++) send(4'($urandom));
    wait_idle();

    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom % 20 == 0) begin
        for (int i = 0; i < 4; i++)
          rp[3*i +: 3] = ($urandom % 6 == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        do_cfg(16'($urandom), rp, 4'($urandom), 1'($urandom), 0);
      end else begin
        send(4'($urandom));
      end
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle();

    // Asynchronous reset mid-operation with data in flight and a config pending.
    do_cfg(16'hA5C3, 12'b000_001_010_011, 4'h2, 1'b0, 0);
    out_ready = 1'b0;
    send(4'h3);
    send(4'h7);
    cfg_we = 1'b1;
    cfg_tt = 16'hFFFF;
    cfg_perm = 12'b011_010_001_000;
    cfg_neg_in = 4'h0;
    cfg_neg_out = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_eval_cnt", eval_cnt, 0);
    sb_q.delete();
    model_reset();
    cfg_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_pulse", cfg_ack | cfg_err, 0);
    end
    out_ready = 1'b1;
    send(4'hF);
    send(4'h6);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/npn_eval_pipe.md
NPN_EVAL_PIPE -- requirements
Module: npn_eval_pipe

Interface
REQ-001 Parameter N_IN, default 4, legal 2..6: number of function inputs.
REQ-002 Parameter TT_W, default 2**N_IN, derived, not overridden: truth-table width.
REQ-003 Parameter CNT_W, default 16: width of the evaluation counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 cfg_we  in  1  config write request.
REQ-007 cfg_tt  in  TT_W  truth table; bit k = f(index k), where x0 is the index LSB.
REQ-008 cfg_perm  in  3*N_IN  permutation; field i (bits 3i+2:3i) = source input index for position i.
REQ-009 cfg_neg_in  in  N_IN  per-position input negation mask.
REQ-010 cfg_neg_out  in  1  output negation.
REQ-011 cfg_ack  out  1  one-cycle pulse: config accepted.
REQ-012 cfg_err  out  1  one-cycle pulse: config rejected.
REQ-013 in_valid / in_ready  in / out  1 each  input handshake.
REQ-014 in_x  in  N_IN  input vector x0..x(N_IN-1).
REQ-015 out_valid / out_ready  out / in  1 each  output handshake.
REQ-016 out_y  out  1  function result y0.
REQ-017 eval_cnt  out  CNT_W  saturating count of results delivered.
REQ-018 busy  out  1  high while either pipeline stage holds valid data.

Function
REQ-019 Transfer occurs when valid and ready are both high on a rising edge; valid and data are held stable until the transfer.
REQ-020 Stage 1 registers p[i] = in_x[perm_i] XOR neg_in[i] for every i.
REQ-021 Stage 2 registers out_y = cfg_tt[p] XOR neg_out, with p read as an unsigned index.
REQ-022 Latency is exactly 2 cycles from input transfer to out_valid when no stall occurs.
REQ-023 Throughput is one result per cycle while out_ready is held high.
REQ-024 When stage 2 is full and out_ready is low, stage 2 holds its contents.
REQ-025 When stage 2 is stalled, stage 1 holds its contents if full, or accepts one item if empty.
REQ-026 in_ready = !cfg_we AND (stage 1 empty OR stage 1 advancing this cycle).
REQ-027 The state machine has three states: RUN, DRAIN and COMMIT.
REQ-028 RUN: a cfg_we with busy=0 goes directly to COMMIT; a cfg_we with busy=1 goes to DRAIN.
REQ-029 DRAIN: in_ready=0; the block waits for busy=0 and then goes to COMMIT.
REQ-030 COMMIT: the block validates the held config and pulses cfg_ack or cfg_err, then returns to RUN.
REQ-031 cfg_* is held stable by the requester from the cfg_we assertion until the ack or err pulse; cfg_we is deasserted the cycle after that pulse.
REQ-032 Validation: any cfg_perm field >= N_IN causes rejection; on rejection the active config is unchanged.
REQ-033 Duplicate perm indices are legal.
REQ-034 Results already in flight always use the config that was active when they were accepted.
REQ-035 eval_cnt increments on each output transfer and saturates at 2**CNT_W-1.
REQ-036 eval_cnt clears to 0 on a cfg_ack pulse, and the clear takes priority over a simultaneous increment.

Reset
REQ-037 On rst_n low, all state clears immediately regardless of clk.
REQ-038 Reset values: out_valid=0, out_y=0, cfg_ack=0, cfg_err=0, eval_cnt=0, busy=0, state=RUN.
REQ-039 Reset config: cfg_tt=0, perm field i=i, neg_in=0, neg_out=0.
REQ-040 in_ready is high from the first edge after rst_n deasserts.
REQ-041 Reset mid-operation discards in-flight data and any pending config with no ack or err pulse.

Verification
REQ-042 Reset, then send in_x=4'hF with out_ready=1 -> out_valid 2 cycles later with out_y=0, eval_cnt=1.
REQ-043 Config tt=16'h8000, identity perm, neg=0; send 4'hF then 4'hE back-to-back -> cfg_ack, then out_y=1 and out_y=0 on consecutive cycles, eval_cnt=2.
REQ-044 Same config with neg_in=4'hF, neg_out=1; send 4'h0 -> out_y=0; send 4'h5 -> out_y=1.
REQ-045 perm={0,1,2,3} (field0=3, reversal) with tt=16'h0002; send 4'h8 -> out_y=1; send 4'h1 -> out_y=0.
REQ-046 Hold out_ready=0 and stream 3 inputs -> in_ready drops after 2 accepts; release out_ready -> 3 results in order with no loss or duplication.
REQ-047 Issue cfg_we with 2 items in flight and field2=5 -> DRAIN, both old-config results delivered, then cfg_err; old config still active and eval_cnt not cleared.
